sfq_clk2_stim_tx: RTL
=====================

Name: sfq_clk2_stim_tx

Overview:
- Synthesizable transmitter that drives toggle-encoded SFQ pulse lines into a clocked two-input gate (AND2T-class cell), then checks the gate's toggle-encoded output.
- On the encoding, a transition in either direction on a line is one pulse.
- Accepts one operand pair per valid/ready handshake, emits data pulses, waits the setup window, fires the gate clock pulse, honours the hold window, then samples the response window and reports the result.
- Sits in the digital stimulus/checker harness between the sequencer and the cell under test.

Parameters:
- SETUP_CYC, 4: cycles between the data pulses and the clock pulse (min 1).
- HOLD_CYC, 3: cycles after the clock pulse during which no new data pulse may issue (min 1).
- RESP_WIN, 12: cycles after the clock pulse in which the q pulse must arrive (must be > HOLD_CYC).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  1  operand a (1 = emit pulse on a_tgl).
- in_b  in  1  operand b (1 = emit pulse on b_tgl).
- a_tgl  out  1  toggle-encoded pulse line to gate input a.
- b_tgl  out  1  toggle-encoded pulse line to gate input b.
- clk_tgl  out  1  toggle-encoded pulse line to the gate clock.
- q_tgl  in  1  toggle-encoded gate output; synchronous to clk.
- res_valid  out  1  one-cycle strobe: result available.
- res_q  out  1  1 if exactly one q pulse was seen in the window.
- res_err  out  1  result mismatch or protocol violation.
- spurious  out  1  sticky: q pulse seen outside any window; cleared only by reset.
- tx_count  out  CNT_W  completed transactions (feature-gated).
- err_count  out  CNT_W  transactions with res_err (feature-gated).

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs go to 0; in_ready goes to 0 and rises the first cycle after rst_n deasserts.
  - The FSM returns to IDLE, counters clear, and q_prev loads 0.
  - Reset while a toggle line is high drives it low, which the gate sees as one pulse. This is accepted, documented behaviour.
- Edge detect: q_prev is a register of q_tgl; q_edge = q_tgl ^ q_prev.
- FSM states: IDLE, DATA, SETUP, FIRE, HOLD, WAIT, REPORT.
  - IDLE: in_ready=1. On in_valid&in_ready, latch a/b and compute exp = a&b, then go to DATA.
  - DATA (1 cycle): a_tgl toggles if a=1; b_tgl toggles if b=1. Go to SETUP.
  - SETUP: count SETUP_CYC cycles, then go to FIRE.
  - FIRE (1 cycle): clk_tgl toggles; window counter starts at 1. Go to HOLD.
  - HOLD: runs until the counter reaches HOLD_CYC, then go to WAIT.
  - WAIT: runs until the counter reaches RESP_WIN, then go to REPORT.
  - REPORT (1 cycle): res_valid=1, then return to IDLE.
- Response window is the FIRE-following cycles through HOLD and WAIT, RESP_WIN cycles total. Each q_edge there increments a 2-bit saturating pulse count.
- Results at REPORT:
  - res_q = (count == 1).
  - res_err = (count > 1) | (res_q != exp).
- Latency: handshake to res_valid = SETUP_CYC + RESP_WIN + 3 cycles. With defaults, 19 cycles.
- in_ready is 0 in every state except IDLE. Back-to-back transactions therefore have at least one idle cycle; there is no pipelining.
- Any q_edge in IDLE, DATA or SETUP sets spurious. It is not counted toward the transaction.
- Simultaneous events:
  - A q_edge in the REPORT cycle is treated as outside the window and sets spurious.
  - in_valid during REPORT is not accepted until IDLE.
- a=b=0 is legal: only clk_tgl toggles, and exp=0.
- Toggle line levels persist across transactions; only transitions are meaningful.

Optional Feature:
- SFQ_TX_STATS_EN defined:
  - tx_count increments at each REPORT.
  - err_count increments at REPORT when res_err=1.
  - Both saturate at all-ones and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package sfq_tx_pkg holds:
  - the state enum typedef;
  - default window constants;
  - the width localparam for the window counter, $clog2(RESP_WIN+1).
- One sub-module, sfq_toggle_edge: a q_tgl register plus XOR edge detector, reusable by other checker blocks.

Test Plan:
- a=1,b=1, bench flips q_tgl 9 cycles after the clk_tgl toggle -> res_valid at cycle 19 with res_q=1, res_err=0; a_tgl, b_tgl and clk_tgl each change level exactly once.
- a=1,b=0, no q edge -> res_q=0, res_err=0; only a_tgl and clk_tgl toggle.
- a=0,b=1, bench flips q_tgl once in WAIT -> res_q=1, res_err=1; err_count=1 when SFQ_TX_STATS_EN is defined.
- a=1,b=1, bench flips q_tgl twice inside the window -> res_q=0, res_err=1.
- q_tgl flip during SETUP -> spurious=1 and stays set through later clean transactions until rst_n=0.
- rst_n pulsed low during HOLD with a_tgl=1 -> all outputs 0 immediately, FSM back in IDLE, in_ready=1 one cycle after release, tx_count=0.

Source files
------------

// File: rtl/sfq_tx_pkg.sv
// Shared types and default timing constants for the SFQ clocked-gate stimulus transmitter.
package sfq_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_SETUP,
        S_FIRE,
        S_HOLD,
        S_WAIT,
        S_REPORT
    } tx_state_e;

    localparam int SETUP_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF  = 3;
    localparam int RESP_WIN_DEF  = 12;
    localparam int CNT_W_DEF     = 16;
    localparam int WIN_CNT_W     = $clog2(RESP_WIN_DEF + 1);

    // Window counter width for a given window length.
    function automatic int win_cnt_w(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/sfq_toggle_edge.sv
// Toggle-encoded line edge detector: registers the line and flags any level change as one pulse.
module sfq_toggle_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tgl,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= i_tgl;
    end

    assign o_edge = i_tgl ^ r_prev;

endmodule

// File: rtl/sfq_clk2_stim_tx.sv
// Stimulus transmitter/checker for a clocked two-input SFQ gate.
// Optional statistics counters are built when SFQ_TX_STATS_EN is defined.
module sfq_clk2_stim_tx
    import sfq_tx_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF,
    parameter int RESP_WIN  = RESP_WIN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    output logic             a_tgl,
    output logic             b_tgl,
    output logic             clk_tgl,
    input  logic             q_tgl,
    output logic             res_valid,
    output logic             res_q,
    output logic             res_err,
    output logic             spurious,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] err_count
);

    // One counter serves both the setup wait and the response window.
    localparam int CW = win_cnt_w((SETUP_CYC > RESP_WIN) ? SETUP_CYC : RESP_WIN);

    tx_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_wcnt;
    logic [1:0]    r_pcnt;
    logic          r_a, r_b, r_exp, r_rdy;
    logic          r_a_tgl, r_b_tgl, r_clk_tgl, r_spur;
    logic          w_q_edge, w_accept, w_in_win, w_report, w_res_q, w_res_err;

    sfq_toggle_edge u_q_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_tgl  (q_tgl),
        .o_edge (w_q_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE:   if (in_valid && r_rdy) begin
                          w_accept    = 1'b1;
                          w_state_nxt = S_DATA;
                      end
            S_DATA:   w_state_nxt = S_SETUP;
            S_SETUP:  if (r_wcnt == CW'(SETUP_CYC)) w_state_nxt = S_FIRE;
            S_FIRE:   w_state_nxt = S_HOLD;
            S_HOLD:   if (r_wcnt == CW'(HOLD_CYC)) w_state_nxt = S_WAIT;
            S_WAIT:   if (r_wcnt == CW'(RESP_WIN)) w_state_nxt = S_REPORT;
            S_REPORT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_in_win  = (r_state == S_HOLD) || (r_state == S_WAIT);
    assign w_report  = (r_state == S_REPORT);
    assign w_res_q   = (r_pcnt == 2'd1);
    assign w_res_err = (r_pcnt > 2'd1) || (w_res_q != r_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 1'b0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_exp     <= 1'b0;
            r_pcnt    <= 2'd0;
            r_wcnt    <= '0;
            r_a_tgl   <= 1'b0;
            r_b_tgl   <= 1'b0;
            r_clk_tgl <= 1'b0;
            r_spur    <= 1'b0;
        end else begin
            // Ready is registered so it stays low through reset and rises one cycle after release.
            r_rdy <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_a    <= in_a;
                r_b    <= in_b;
                r_exp  <= in_a & in_b;
                r_pcnt <= 2'd0;
            end
            if (r_state == S_DATA) begin
                r_a_tgl <= r_a_tgl ^ r_a;
                r_b_tgl <= r_b_tgl ^ r_b;
                r_wcnt  <= CW'(1);
            end else if (r_state == S_FIRE) begin
                r_clk_tgl <= ~r_clk_tgl;
                r_wcnt    <= CW'(1);
            end else if (r_state == S_SETUP || w_in_win) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_in_win && w_q_edge && r_pcnt != 2'd3) r_pcnt <= r_pcnt + 2'd1;
            if (!w_in_win && w_q_edge) r_spur <= 1'b1;
        end
    end

    assign in_ready  = r_rdy;
    assign a_tgl     = r_a_tgl;
    assign b_tgl     = r_b_tgl;
    assign clk_tgl   = r_clk_tgl;
    assign res_valid = w_report;
    assign res_q     = w_report & w_res_q;
    assign res_err   = w_report & w_res_err;
    assign spurious  = r_spur;

`ifdef SFQ_TX_STATS_EN
    logic [CNT_W-1:0] r_tx_cnt, r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (w_report) begin
            if (~&r_tx_cnt) r_tx_cnt <= r_tx_cnt + 1'b1;
            if (w_res_err && ~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign tx_count  = r_tx_cnt;
    assign err_count = r_err_cnt;
`else
    assign tx_count  = '0;
    assign err_count = '0;
`endif

endmodule
